// File: rtl/ualink_dpmem_fifo_ctrl_if.sv
// Stream and dual-port RAM signals of the dpmem FIFO controller.
// The controller takes the master view; the upstream/downstream/RAM side takes the slave view.
interface ualink_dpmem_fifo_ctrl_if #(
    parameter int DPADDR_WIDTH = 8,
    parameter int DPDATA_WIDTH = 64
);
    logic                    s_valid;
    logic                    s_ready;
    logic [DPDATA_WIDTH-1:0] s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [DPDATA_WIDTH-1:0] m_data;
    logic                    ram_we_a;
    logic [DPADDR_WIDTH-1:0] ram_addr_a;
    logic [DPDATA_WIDTH-1:0] ram_din_a;
    logic                    ram_we_b;
    logic [DPADDR_WIDTH-1:0] ram_addr_b;
    logic [DPDATA_WIDTH-1:0] ram_din_b;
    logic [DPDATA_WIDTH-1:0] ram_dout_b;

    modport master (
        input  s_valid, s_data, m_ready, ram_dout_b,
        output s_ready, m_valid, m_data,
        output ram_we_a, ram_addr_a, ram_din_a,
        output ram_we_b, ram_addr_b, ram_din_b
    );

    modport slave (
        output s_valid, s_data, m_ready, ram_dout_b,
        input  s_ready, m_valid, m_data,
        input  ram_we_a, ram_addr_a, ram_din_a,
        input  ram_we_b, ram_addr_b, ram_din_b
    );
endinterface

// File: rtl/ualink_dpmem_fifo_ctrl.sv
// Valid/ready FIFO over a dual-port RAM: port A writes, port B reads, and a
// 2-entry output buffer hides the RAM's registered read latency.
module ualink_dpmem_fifo_ctrl #(
    parameter int DPADDR_WIDTH = 8,
    parameter int DPDATA_WIDTH = 64
) (
    input  logic                      axi_aclk,
    input  logic                      axi_resetn,
    input  logic                      flush,
    ualink_dpmem_fifo_ctrl_if.master  bus,
    output logic [DPADDR_WIDTH:0]     level,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = DPADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = PW'(1) << DPADDR_WIDTH;

    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } ob_state_e;

    logic [PW-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                       rd_ptr_q, rd_ptr_d;
    logic                                inflight_q, inflight_d;
    ob_state_e                           ob_state_q, ob_state_d;
    logic [1:0][DPDATA_WIDTH-1:0]        obuf_q, obuf_d;
    logic                                m_valid_q, m_valid_d;

    logic                                s_ready;
    logic                                wr_en;
    logic                                pop;
    logic                                push;
    logic                                issue;
    logic [2:0]                          occ;
    logic                                wr_slot;

    // Handshake and issue decisions, all from registered state plus live inputs.
    always_comb begin
        level   = wr_ptr_q - rd_ptr_q;
        full    = (level == DEPTH);
        s_ready = !full && !flush;
        // Gating on reset keeps the RAM write strobe low while held in reset.
        wr_en   = bus.s_valid && s_ready && axi_resetn;
        pop     = m_valid_q && bus.m_ready;
        push    = inflight_q;
        occ     = {1'b0, ob_state_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue   = (level != '0) && (occ < 3'd2);
        empty   = (level == '0) && (ob_state_q == OB_EMPTY) && !inflight_q;
        wr_slot = (ob_state_q == OB_TWO) || ((ob_state_q == OB_ONE) && !pop);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(wr_en);
        rd_ptr_d   = rd_ptr_q + PW'(issue);
        inflight_d = issue;

        obuf_d = obuf_q;
        if (pop) begin
            obuf_d[0] = obuf_q[1];
        end
        // Returning word lands behind whatever survives this cycle's pop.
        if (push) begin
            obuf_d[wr_slot] = bus.ram_dout_b;
        end

        ob_state_d = ob_state_q;
        unique case (ob_state_q)
            OB_EMPTY: if (push)              ob_state_d = OB_ONE;
            OB_ONE: begin
                if (push && !pop)            ob_state_d = OB_TWO;
                else if (!push && pop)       ob_state_d = OB_EMPTY;
            end
            OB_TWO:   if (pop && !push)      ob_state_d = OB_ONE;
            default:                         ob_state_d = OB_EMPTY;
        endcase

        // Flush wins over everything, including a read returning this cycle.
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
            ob_state_d = OB_EMPTY;
        end

        m_valid_d = (ob_state_d != OB_EMPTY);
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            ob_state_q <= OB_EMPTY;
            obuf_q     <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            ob_state_q <= ob_state_d;
            obuf_q     <= obuf_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = obuf_q[0];
    assign bus.ram_we_a   = wr_en;
    assign bus.ram_addr_a = wr_ptr_q[DPADDR_WIDTH-1:0];
    assign bus.ram_din_a  = bus.s_data;
    assign bus.ram_we_b   = 1'b0;
    assign bus.ram_addr_b = rd_ptr_q[DPADDR_WIDTH-1:0];
    assign bus.ram_din_b  = '0;

    ap_no_obuf_overflow: assert property (@(posedge axi_aclk) disable iff (!axi_resetn || flush)
        !(inflight_q && !pop && (ob_state_q == OB_TWO)));

    ap_level_bounded: assert property (@(posedge axi_aclk) disable iff (!axi_resetn)
        level <= DEPTH);

    ap_no_write_when_full: assert property (@(posedge axi_aclk) disable iff (!axi_resetn)
        !(wr_en && full));

endmodule

// File: tb/tb_ualink_dpmem_fifo_ctrl.sv
// Random-stimulus scoreboard bench for the dpmem FIFO controller with a behavioural RAM.
module tb_ualink_dpmem_fifo_ctrl;

    localparam int AW = 8;
    localparam int DW = 64;

    logic          axi_aclk   = 1'b0;
    logic          axi_resetn = 1'b0;
    logic          flush      = 1'b0;
    logic [AW:0]   level;
    logic          full;
    logic          empty;

    ualink_dpmem_fifo_ctrl_if #(.DPADDR_WIDTH(AW), .DPDATA_WIDTH(DW)) u ();

    ualink_dpmem_fifo_ctrl #(.DPADDR_WIDTH(AW), .DPDATA_WIDTH(DW)) dut (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .flush      (flush),
        .bus        (u),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    always #5 axi_aclk = ~axi_aclk;

    int cyc = 0;
    always @(posedge axi_aclk) cyc <= cyc + 1;

    // Behavioural 2^AW x DW RAM with a registered port-B read.
    logic [DW-1:0] mem [2**AW];
    always @(posedge axi_aclk) begin
        if (u.ram_we_a) mem[u.ram_addr_a] <= u.ram_din_a;
        if (u.ram_we_b) mem[u.ram_addr_b] <= u.ram_din_b;
        u.ram_dout_b <= mem[u.ram_addr_b];
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted word must come out once, in order.
    logic [DW-1:0] exp_q[$];
    int            pop_cnt      = 0;
    int            first_pop_cyc = 0;
    int            last_pop_cyc  = 0;
    logic          stall_v = 1'b0;
    logic [DW-1:0] stall_d = '0;

    initial begin : monitor
        forever begin
            @(negedge axi_aclk);
            if (!axi_resetn || flush) begin
                exp_q.delete();
                stall_v = 1'b0;
            end else begin
                if (stall_v) begin
                    chk("stall_valid", 64'(u.m_valid), 64'd1);
                    chk("stall_data", u.m_data, stall_d);
                end
                if (u.m_valid && u.m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL out_unexpected: got %h expected no output (cycle %0d)", u.m_data, cyc);
                    end else begin
                        chk("out_data", u.m_data, exp_q.pop_front());
                    end
                    if (pop_cnt == 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    pop_cnt++;
                end
                stall_v = u.m_valid && !u.m_ready;
                stall_d = u.m_data;
                if (u.s_valid && u.s_ready) exp_q.push_back(u.s_data);
            end
        end
    end

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic stream(input int n, input int sv_pct, input int mr_pct, input bit seq,
                          input logic [63:0] base, input int budget, output int cycles);
        int sent;
        logic [63:0] d;
        sent   = 0;
        cycles = 0;
        d = seq ? base : {$urandom(), $urandom()};
        while (sent < n && cycles < budget) begin
            u.s_valid = ($urandom_range(0, 99) < sv_pct);
            u.s_data  = d;
            u.m_ready = ($urandom_range(0, 99) < mr_pct);
            @(negedge axi_aclk);
            if (u.s_valid && u.s_ready) begin
                sent++;
                d = seq ? base + 64'(sent) : {$urandom(), $urandom()};
            end
            cycles++;
            tick();
        end
        u.s_valid = 1'b0;
        chk("stream_sent", 64'(sent), 64'(n));
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        u.s_valid = 1'b0;
        u.m_ready = 1'b1;
        while (!(exp_q.size() == 0 && empty) && c < budget) begin
            tick();
            c++;
        end
        chk("drain_done", 64'(exp_q.size() == 0 && empty), 64'd1);
    endtask

    task automatic single_word(input logic [63:0] d);
        u.s_valid = 1'b1;
        u.s_data  = d;
        u.m_ready = 1'b1;
        @(negedge axi_aclk);
        chk("sw_accept", 64'(u.s_ready), 64'd1);
        tick();
        u.s_valid = 1'b0;
        @(negedge axi_aclk);
        chk("sw_lat_n0", 64'(u.m_valid), 64'd0);
        @(negedge axi_aclk);
        chk("sw_lat_n1", 64'(u.m_valid), 64'd0);
        @(negedge axi_aclk);
        chk("sw_lat_n2_valid", 64'(u.m_valid), 64'd1);
        chk("sw_lat_n2_data", u.m_data, d);
        @(negedge axi_aclk);
        chk("sw_empty_after", 64'(empty), 64'd1);
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc_used;
        int got;
        u.s_valid = 1'b1;
        u.s_data  = 64'h0123_4567_89AB_CDEF;
        u.m_ready = 1'b0;

        // Reset values, with s_valid high to prove the write strobe is held off.
        #12;
        chk("rst_m_valid", 64'(u.m_valid), 64'd0);
        chk("rst_m_data", u.m_data, 64'd0);
        chk("rst_s_ready", 64'(u.s_ready), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_we_a", 64'(u.ram_we_a), 64'd0);
        chk("rst_addr_a", 64'(u.ram_addr_a), 64'd0);
        chk("rst_addr_b", 64'(u.ram_addr_b), 64'd0);
        chk("rst_we_b", 64'(u.ram_we_b), 64'd0);
        u.s_valid = 1'b0;
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        tick();

        single_word(64'hDEADBEEF_CAFEBABE);

        // Back-to-back streaming across multiple pointer wraps.
        pop_cnt = 0;
        stream(600, 100, 100, 1'b1, 64'd0, 1000, cyc_used);
        chk("stream_in_rate", 64'(cyc_used), 64'd600);
        drain(50);
        chk("stream_out_cnt", 64'(pop_cnt), 64'd600);
        chk("stream_out_rate", 64'(last_pop_cyc - first_pop_cyc), 64'd599);

        // Fill RAM plus output buffer, then prove the next word is refused.
        stream(258, 100, 0, 1'b1, 64'h0001_0000, 400, cyc_used);
        chk("fill_rate", 64'(cyc_used), 64'd258);
        u.s_valid = 1'b1;
        u.s_data  = 64'h0001_0000 + 64'd258;
        repeat (4) begin
            @(negedge axi_aclk);
            chk("full_blocks", 64'(u.s_ready), 64'd0);
            tick();
        end
        chk("full_level", 64'(level), 64'd256);
        chk("full_flag", 64'(full), 64'd1);
        u.s_valid = 1'b0;
        u.m_ready = 1'b1;
        tick();
        u.m_ready = 1'b0;
        got = 0;
        repeat (2) begin
            @(negedge axi_aclk);
            if (u.s_ready) got = 1;
            tick();
        end
        chk("sready_reassert", 64'(got), 64'd1);
        drain(400);

        // Random backpressure with random source gaps.
        stream(1000, 90, 50, 1'b0, 64'd0, 5000, cyc_used);
        drain(300);

        // Flush with 10 words resident and one read in flight.
        stream(13, 100, 0, 1'b1, 64'h0F00, 50, cyc_used);
        repeat (4) tick();
        @(negedge axi_aclk);
        chk("flush_pre_level", 64'(level), 64'd11);
        tick();
        u.m_ready = 1'b1;
        tick();
        u.m_ready = 1'b0;
        flush     = 1'b1;
        u.s_valid = 1'b1;
        u.s_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge axi_aclk);
        chk("flush_s_ready", 64'(u.s_ready), 64'd0);
        chk("flush_we_a", 64'(u.ram_we_a), 64'd0);
        chk("flush_level_in", 64'(level), 64'd10);
        tick();
        flush     = 1'b0;
        u.s_valid = 1'b0;
        @(negedge axi_aclk);
        chk("flush_m_valid", 64'(u.m_valid), 64'd0);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        tick();
        single_word(64'h1111111111111111);

        // Asynchronous reset in the middle of a stream.
        stream(20, 100, 100, 1'b1, 64'h0000_A000, 50, cyc_used);
        u.s_valid = 1'b1;
        u.s_data  = 64'h0000_B000;
        u.m_ready = 1'b0;
        tick();
        #2;
        axi_resetn = 1'b0;
        #1;
        chk("arst_m_valid", 64'(u.m_valid), 64'd0);
        chk("arst_m_data", u.m_data, 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_full", 64'(full), 64'd0);
        chk("arst_s_ready", 64'(u.s_ready), 64'd1);
        chk("arst_we_a", 64'(u.ram_we_a), 64'd0);
        chk("arst_addr_b", 64'(u.ram_addr_b), 64'd0);
        u.s_valid = 1'b0;
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        tick();
        single_word(64'h5A5A_0000_1234_5678);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
